// File: rtl/serial_mag_comparator_pkg.sv
// serial_mag_comparator_pkg: shared FSM encodings and digit width for the serial comparator.
package serial_mag_comparator_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int DIGIT_W = 2;
endpackage

// File: rtl/serial_mag_comparator_digit.sv
// comparator_2bit: combinational 2-bit unsigned magnitude comparator used as the digit stage.
module comparator_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       l,
    output logic       g,
    output logic       e
);
    assign l = a < b;
    assign g = a > b;
    assign e = a == b;
endmodule

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: MSB-first, 2-bits-per-clock unsigned compare with early exit on the first unequal digit.
module serial_mag_comparator
    import serial_mag_comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);
    localparam int ND = WIDTH / DIGIT_W;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;
    logic             dig_l, dig_g, dig_e;

    comparator_2bit u_digit (
        .a(sa_q[WIDTH-1 -: DIGIT_W]),
        .b(sb_q[WIDTH-1 -: DIGIT_W]),
        .l(dig_l),
        .g(dig_g),
        .e(dig_e)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                sa_d    = a_in;
                sb_d    = b_in;
                cnt_d   = '0;
                {lt_d, gt_d, eq_d} = 3'b000;
            end
            RUN: if (!dig_e) begin
                state_d = DONE;
                lt_d    = dig_l;
                gt_d    = dig_g;
                eq_d    = 1'b0;
            end else if (cnt_q == CW'(ND - 1)) begin
                state_d = DONE;
                {lt_d, gt_d, eq_d} = 3'b001;
            end else begin
                sa_d  = sa_q << DIGIT_W;
                sb_d  = sb_q << DIGIT_W;
                cnt_d = cnt_q + CW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status outputs are registered, so derive them from the next state.
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign lt   = lt_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Compares two WIDTH-bit unsigned operands serially, 2 bits per clock, MSB digit first.
- Feeds the existing combinational 2-bit comparator stage (inputs a/b, outputs l/g/e) and consumes its per-digit result.
- Terminates early on the first unequal digit.
- Provides a start/busy/done handshake and a held lt/gt/eq result for downstream control logic.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2. Digit count ND = WIDTH/2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a comparison; accepted only in IDLE
- a_in  input  WIDTH  operand A; sampled on the accepting edge
- b_in  input  WIDTH  operand B; sampled on the accepting edge
- busy  output  1  high in RUN and DONE states
- done  output  1  single-cycle pulse; result valid
- lt  output  1  A < B
- gt  output  1  A > B
- eq  output  1  A == B

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. While rst=1: state=IDLE, busy=0, done=0, lt=gt=eq=0, shift registers and digit counter cleared.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE: if start=1 at edge N:
  - Load a_in/b_in into shift registers sa/sb.
  - Digit counter cnt=0.
  - Clear lt/gt/eq to 0.
  - Next state RUN. busy=1 from N+1.
- RUN, cycle N+1+k, digit k = 0..ND-1: sa[WIDTH-1:WIDTH-2] and sb[WIDTH-1:WIDTH-2] drive the 2-bit comparator.
  - e=0: latch lt=l, gt=g, eq=0; next state DONE.
  - e=1 and cnt==ND-1: latch eq=1, lt=gt=0; next state DONE.
  - e=1 otherwise: shift sa/sb left by 2, cnt+1, stay in RUN.
- DONE: done=1 for exactly this one cycle, busy=1; next state IDLE.
- Latency: start edge N, first mismatch at digit k, gives done at cycle N+2+k. Equal operands give done at cycle N+1+ND.
- Result hold: lt/gt/eq are held after DONE until the next accepted start. After done, exactly one of the three is 1.
- start while busy=1 (RUN or DONE) is ignored and not queued. a_in/b_in changes after acceptance have no effect.
- Earliest back-to-back start is the cycle after done (IDLE).
- rst asserted mid-operation aborts immediately: no done pulse, outputs zeroed, IDLE.
- cnt width is clog2(ND), min 1. It never wraps, because RUN exits at ND-1.
- Illegal state encoding returns to IDLE.

Decomposition:
- Shared header/package holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - DIGIT_W=2 localparam
- Sub-module: instantiate the existing comparator_2bit (a, b, l, g, e) once as the digit stage.
- FSM, shift registers, counter and result registers stay in this module.

Test Plan (WIDTH=8, start pulsed 1 cycle at edge N):
- a=8'hA5, b=8'hA5: all digits equal, so done at N+5; eq=1, lt=gt=0; busy high N+1..N+5.
- a=8'hC0, b=8'h40: digit0 is 11 vs 01, so done at N+2; gt=1, lt=eq=0.
- a=8'h12, b=8'h13: mismatch at digit3 (10 vs 11), so done at N+5; lt=1.
- start re-pulsed at N+2 with a=8'h00, b=8'hFF during a=b=8'h5A compare: ignored; done at N+5 with eq=1; the following IDLE start compares fresh operands (lt=1, done 2 cycles later).
- rst asserted at N+3 of an 8'hFF/8'hFF compare: outputs immediately 0, busy=0, no done pulse. A new start after release behaves normally.
- Random 200 operand pairs against a behavioural reference: check result, done timing N+2+k, and exactly one done pulse per accepted start.
